// File: rtl/vc_demux2_pipe.sv
// rtl/vc_demux2_pipe.sv - 1-to-2 val/rdy demultiplexer with one registered entry per lane
// Optional per-lane delivery counters: define VC_DEMUX_COUNT_EN.
module vc_demux2_pipe #(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic                   in_sel,
    input  logic [p_nbits-1:0]     in_msg,
    output logic                   out0_val,
    input  logic                   out0_rdy,
    output logic [p_nbits-1:0]     out0_msg,
    output logic                   out1_val,
    input  logic                   out1_rdy,
    output logic [p_nbits-1:0]     out1_msg
`ifdef VC_DEMUX_COUNT_EN
    ,
    output logic [p_cnt_nbits-1:0] cnt0,
    output logic [p_cnt_nbits-1:0] cnt1
`endif
);

    logic               full0_q, full0_d;
    logic               full1_q, full1_d;
    logic [p_nbits-1:0] buf0_q, buf0_d;
    logic [p_nbits-1:0] buf1_q, buf1_d;
    logic               enq0, enq1, deq0, deq1;

    // A lane can accept when empty or when its current entry leaves this cycle.
    always_comb begin
        in_rdy = in_sel ? (!full1_q || out1_rdy) : (!full0_q || out0_rdy);
        enq0   = in_val && in_rdy && !in_sel;
        enq1   = in_val && in_rdy &&  in_sel;
        deq0   = full0_q && out0_rdy;
        deq1   = full1_q && out1_rdy;

        full0_d = full0_q;
        buf0_d  = buf0_q;
        if (enq0) begin
            full0_d = 1'b1;
            buf0_d  = in_msg;
        end else if (deq0) begin
            full0_d = 1'b0;
        end

        full1_d = full1_q;
        buf1_d  = buf1_q;
        if (enq1) begin
            full1_d = 1'b1;
            buf1_d  = in_msg;
        end else if (deq1) begin
            full1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    assign out0_val = full0_q;
    assign out0_msg = buf0_q;
    assign out1_val = full1_q;
    assign out1_msg = buf1_q;

`ifdef VC_DEMUX_COUNT_EN
    logic [p_cnt_nbits-1:0] cnt0_q, cnt0_d;
    logic [p_cnt_nbits-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (deq0) cnt0_d = cnt0_q + 1'b1;
        if (deq1) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
